breath_duty_gen: RTL and testbench

Upstream duty-profile generator for the PWM breathing-LED stage. It produces a triangle-shaped duty value: ramp up, hold at the top, ramp down, hold at the bottom. The duty changes only at PWM period boundaries, which the downstream PWM stage signals with period_end. It replaces a fixed duty lookup with parameterised ramp rate, limits and hold times, and adds a graceful fade-out when disabled.

---
 rtl/breath_duty_gen.sv | 148 ++++++++++++++
 tb/tb_breath_duty_gen.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/breath_duty_gen.sv
// Triangle duty-profile generator for the breathing-LED PWM stage.
// Duty moves only on period_end so the PWM stage always sees a whole period at one value.
module breath_duty_gen #(
  parameter int DUTY_W           = 19,
  parameter int PERIOD           = 500000,
  parameter int DUTY_MIN         = 25000,
  parameter int DUTY_MAX         = 475000,
  parameter int STEP             = 25000,
  parameter int PERIODS_PER_STEP = 15,
  parameter int HOLD_PERIODS     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              period_end,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_upd,
  output logic [2:0]        phase,
  output logic              cycle_done
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RISE     = 3'd1;
  localparam logic [2:0] S_HOLD_TOP = 3'd2;
  localparam logic [2:0] S_FALL     = 3'd3;
  localparam logic [2:0] S_HOLD_BOT = 3'd4;

  localparam int DW1    = DUTY_W + 1;
  localparam int PC_MAX = (PERIODS_PER_STEP > HOLD_PERIODS) ? PERIODS_PER_STEP : HOLD_PERIODS;
  localparam int PC_W   = $clog2(PC_MAX + 1);

  localparam logic [PC_W-1:0]   STEP_LAST = PC_W'(PERIODS_PER_STEP - 1);
  localparam logic [PC_W-1:0]   HOLD_LAST = PC_W'(HOLD_PERIODS - 1);
  localparam logic [DUTY_W-1:0] MIN_V     = DUTY_W'(DUTY_MIN);
  localparam logic [DUTY_W-1:0] MAX_V     = DUTY_W'(DUTY_MAX);
  localparam logic [DW1-1:0]    MAX_X     = DW1'(DUTY_MAX);
  localparam logic [DW1-1:0]    STEP_X    = DW1'(STEP);
  localparam logic [DW1-1:0]    FLOOR_X   = DW1'(DUTY_MIN + STEP);

  logic [2:0]      state;
  logic [PC_W-1:0] pc;
  logic [DW1-1:0]  duty_x;
  logic [DW1-1:0]  up_x;
  logic [DW1-1:0]  dn_x;

  // One extra bit so duty+STEP cannot wrap before the limit compare.
  assign duty_x = {1'b0, duty};
  assign up_x   = duty_x + STEP_X;
  assign dn_x   = duty_x - STEP_X;
  assign phase  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      duty       <= MIN_V;
      duty_upd   <= 1'b0;
      cycle_done <= 1'b0;
      pc         <= '0;
    end else begin
      duty_upd   <= 1'b0;
      cycle_done <= 1'b0;
      case (state)
        S_IDLE: begin
          duty <= MIN_V;
          if (en) begin
            state <= S_RISE;
            pc    <= '0;
          end
        end
        S_RISE: begin
          // Losing en beats a coincident step: fade from the current duty.
          if (!en) begin
            state <= S_FALL;
            pc    <= '0;
          end else if (period_end) begin
            if (pc == STEP_LAST) begin
              pc <= '0;
              if (up_x >= MAX_X) begin
                duty     <= MAX_V;
                duty_upd <= (duty != MAX_V);
                state    <= S_HOLD_TOP;
              end else begin
                duty     <= up_x[DUTY_W-1:0];
                duty_upd <= 1'b1;
              end
            end else begin
              pc <= pc + 1'b1;
            end
          end
        end
        S_HOLD_TOP: begin
          if (!en) begin
            state <= S_FALL;
            pc    <= '0;
          end else if (period_end) begin
            if (pc == HOLD_LAST) begin
              state <= S_FALL;
              pc    <= '0;
            end else begin
              pc <= pc + 1'b1;
            end
          end
        end
        S_FALL: begin
          if (period_end) begin
            if (pc == STEP_LAST) begin
              pc <= '0;
              if (duty_x <= FLOOR_X) begin
                duty     <= MIN_V;
                duty_upd <= (duty != MIN_V);
                state    <= S_HOLD_BOT;
              end else begin
                duty     <= dn_x[DUTY_W-1:0];
                duty_upd <= 1'b1;
              end
            end else begin
              pc <= pc + 1'b1;
            end
          end
        end
        S_HOLD_BOT: begin
          if (period_end) begin
            if (pc == HOLD_LAST) begin
              cycle_done <= 1'b1;
              state      <= en ? S_RISE : S_IDLE;
              pc         <= '0;
            end else begin
              pc <= pc + 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          duty  <= MIN_V;
          pc    <= '0;
        end
      endcase
    end
  end

  // Parameter sanity, simulation only.
  always @(posedge clk) begin
    param_legal: assert (DUTY_MIN >= 1 && DUTY_MIN < DUTY_MAX && DUTY_MAX <= PERIOD &&
                         (PERIOD >> DUTY_W) == 0 && STEP >= 1 &&
                         PERIODS_PER_STEP >= 1 && HOLD_PERIODS >= 1);
  end

endmodule

// File: tb/tb_breath_duty_gen.sv
// Directed bench for breath_duty_gen: full breath, en drop, idle, async reset, duty stability.
module tb_breath_duty_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       period_end;
  logic [9:0] duty;
  logic       duty_upd;
  logic [2:0] phase;
  logic       cycle_done;

  int tests = 0;
  int fails = 0;

  breath_duty_gen #(
    .DUTY_W(10), .PERIOD(500), .DUTY_MIN(100), .DUTY_MAX(450), .STEP(100),
    .PERIODS_PER_STEP(2), .HOLD_PERIODS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .period_end(period_end),
    .duty(duty), .duty_upd(duty_upd), .phase(phase), .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int d, input int u, input int p, input int c);
    chk({tag, ".duty"}, 32'(duty), d);
    chk({tag, ".upd"}, 32'(duty_upd), u);
    chk({tag, ".phase"}, 32'(phase), p);
    chk({tag, ".cdone"}, 32'(cycle_done), c);
  endtask

  task automatic pe_edge();
    period_end = 1'b1;
    @(posedge clk); #1;
    period_end = 1'b0;
  endtask

  // Seven quiet cycles between period_end pulses: duty must not move.
  task automatic gap(input string tag, input int d);
    repeat (7) begin
      @(posedge clk); #1;
      chk({tag, ".gap_duty"}, 32'(duty), d);
      chk({tag, ".gap_upd"}, 32'(duty_upd), 0);
    end
  endtask

  task automatic step_chk(input string tag, input int d, input int u, input int p, input int c);
    pe_edge();
    chk_all(tag, d, u, p, c);
    gap(tag, d);
  endtask

  int rise_v[4];
  int fall_v[4];
  int prev;

  initial begin
    rise_v = '{200, 300, 400, 450};
    fall_v = '{350, 250, 150, 100};
    rst_n = 1'b0; en = 1'b0; period_end = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 100, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all("idle_no_en", 100, 0, 0, 0);

    // 1: rise
    en = 1'b1;
    @(posedge clk); #1;
    chk_all("en_to_rise", 100, 0, 1, 0);
    prev = 100;
    for (int i = 0; i < 4; i++) begin
      step_chk("rise_wait", prev, 0, 1, 0);
      step_chk("rise_step", rise_v[i], 1, (i == 3) ? 2 : 1, 0);
      prev = rise_v[i];
    end

    // 2: hold top, fall, hold bottom, re-enter rise
    step_chk("top_exit", 450, 0, 3, 0);
    for (int i = 0; i < 4; i++) begin
      step_chk("fall_wait", prev, 0, 3, 0);
      step_chk("fall_step", fall_v[i], 1, (i == 3) ? 4 : 3, 0);
      prev = fall_v[i];
    end
    pe_edge();
    chk_all("bot_exit", 100, 0, 1, 1);
    @(posedge clk); #1;
    chk_all("cdone_1cyc", 100, 0, 1, 0);
    gap("bot_exit", 100);

    // 3: climb to 300, then drop en on a step-completing period_end
    step_chk("r2_wait", 100, 0, 1, 0);
    step_chk("r2_step", 200, 1, 1, 0);
    step_chk("r2_wait", 200, 0, 1, 0);
    step_chk("r2_step", 300, 1, 1, 0);
    step_chk("r2_wait", 300, 0, 1, 0);
    en = 1'b0;
    step_chk("en_drop", 300, 0, 3, 0);
    step_chk("fade_wait", 300, 0, 3, 0);
    step_chk("fade_step", 200, 1, 3, 0);
    step_chk("fade_wait", 200, 0, 3, 0);
    step_chk("fade_step", 100, 1, 4, 0);
    pe_edge();
    chk_all("fade_done", 100, 0, 0, 1);
    gap("fade_done", 100);

    // 4: period_end ignored in IDLE
    for (int i = 0; i < 5; i++) step_chk("idle_pe", 100, 0, 0, 0);

    // 5: async reset mid-fall at 250
    en = 1'b1;
    @(posedge clk); #1;
    chk_all("rst_rise", 100, 0, 1, 0);
    for (int i = 0; i < 8; i++) pe_edge();
    chk_all("rst_at_top", 450, 1, 2, 0);
    pe_edge();
    for (int i = 0; i < 3; i++) pe_edge();
    pe_edge();
    chk_all("rst_pre", 250, 1, 3, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("rst_async", 100, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all("rst_restart", 100, 0, 1, 0);
    step_chk("rst_r_wait", 100, 0, 1, 0);
    step_chk("rst_r_step", 200, 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
